// File: rtl/lcd_char_driver.sv
// lcd_char_driver: HD44780 character-LCD driver with self-run init, valid/ready byte port, cursor tracking and row wrap.
// Ports:
//   clk, rst_n              system clock, asynchronous active-low reset
//   in_valid/in_ready       byte handshake; in_rs selects command (0) or data (1), in_byte is the code
//   init_done               power-on init sequence finished (sticky until reset)
//   busy                    transfer, post-write wait or init in progress
//   rs_out/enable_out/data_out  LCD RS, E and data pins (D7..D4 in 4-bit mode)
module lcd_char_driver #(
  parameter int CLK_HZ        = 12_000_000,
  parameter int BUS_WIDTH     = 4,
  parameter int ROWS          = 2,
  parameter int COLS          = 16,
  parameter int INIT_DELAY_US = 15000,
  parameter int CMD_DELAY_US  = 40,
  parameter int CLR_DELAY_US  = 1600
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_rs,
  input  logic [7:0]           in_byte,
  output logic                 init_done,
  output logic                 busy,
  output logic                 rs_out,
  output logic                 enable_out,
  output logic [BUS_WIDTH-1:0] data_out
);
  if (BUS_WIDTH != 4 && BUS_WIDTH != 8) begin : g_bad_bus
    $error("lcd_char_driver: BUS_WIDTH must be 4 or 8");
  end
  if (ROWS < 1 || ROWS > 4 || COLS < 1 || COLS > 20) begin : g_bad_geom
    $error("lcd_char_driver: ROWS must be 1..4 and COLS 1..20");
  end
  // ceil(ns * CLK_HZ / 1e9) clock cycles, never less than one
  function automatic logic [31:0] cyc(input longint ns);
    longint c;
    c = (ns * longint'(CLK_HZ) + 64'd999_999_999) / 64'd1_000_000_000;
    return (c < 1) ? 32'd1 : c[31:0];
  endfunction
  localparam logic [31:0] T_INIT = cyc(longint'(INIT_DELAY_US) * 1000);
  localparam logic [31:0] T_CMD  = cyc(longint'(CMD_DELAY_US) * 1000);
  localparam logic [31:0] T_CLR  = cyc(longint'(CLR_DELAY_US) * 1000);
  localparam logic [31:0] T_4100 = cyc(64'd4_100_000);
  localparam logic [31:0] T_100  = cyc(64'd100_000);
  localparam logic [31:0] T_EHI  = cyc(64'd450);
  localparam logic [31:0] T_ELO  = cyc(64'd1000);
  localparam bit          BUS8   = (BUS_WIDTH == 8);
  localparam logic [1:0]  LAST_ROW = 2'(ROWS - 1);
  localparam logic [4:0]  NCOL   = 5'(COLS);
  localparam logic [7:0]  FSET   = 8'h20 | (BUS8 ? 8'h10 : 8'h00) | (ROWS > 1 ? 8'h08 : 8'h00);
  typedef enum logic [2:0] {PWR_WAIT, INIT, IDLE, SETUP, E_HI, E_LO, WAIT, WRAP} state_t;
  function automatic logic [6:0] base(input logic [1:0] r);
    return (r == 2'd0) ? 7'h00 : (r == 2'd1) ? 7'h40 : (r == 2'd2) ? 7'h14 : 7'h54;
  endfunction
  // Bus value for one transfer: full byte on an 8-bit bus, else the selected nibble
  function automatic logic [BUS_WIDTH-1:0] bus_val(input logic [7:0] b, input logic lo);
    logic [7:0] v;
    v = BUS8 ? b : {4'h0, lo ? b[3:0] : b[7:4]};
    return v[BUS_WIDTH-1:0];
  endfunction
  state_t      state;
  logic [31:0] cnt, wait_q;
  logic [2:0]  idx;
  logic [7:0]  byte_q;
  logic        half, single, trk, wrap_pend;
  logic [1:0]  row, next_row, hit_row;
  logic [4:0]  col, hit_col;
  logic        hit, clr, accept, load;
  logic [7:0]  ini_byte, ld_byte;
  logic        ini_single;
  logic [31:0] ini_wait, ld_wait;
  // Init table; in 8-bit mode index 3 (the 4-bit switch nibble) is skipped
  always_comb begin
    ini_byte   = 8'h06;
    ini_single = 1'b0;
    ini_wait   = T_CMD;
    case (idx)
      3'd0: begin ini_byte = 8'h30; ini_single = 1'b1; ini_wait = T_4100; end
      3'd1, 3'd2: begin ini_byte = 8'h30; ini_single = 1'b1; ini_wait = T_100; end
      3'd3: begin ini_byte = 8'h20; ini_single = 1'b1; ini_wait = T_100; end
      3'd4: ini_byte = FSET;
      3'd5: ini_byte = 8'h0C;
      3'd6: begin ini_byte = 8'h01; ini_wait = T_CLR; end
      default: ini_byte = 8'h06;
    endcase
  end
  // Set-address decode against each row's window of DDRAM addresses
  always_comb begin
    hit     = 1'b0;
    hit_row = 2'd0;
    hit_col = 5'd0;
    for (int r = 0; r < ROWS; r++) begin
      if ({1'b0, in_byte[6:0]} >= {1'b0, base(2'(r))} &&
          {1'b0, in_byte[6:0]} < {1'b0, base(2'(r))} + 8'(COLS)) begin
        hit     = 1'b1;
        hit_row = 2'(r);
        hit_col = 5'({1'b0, in_byte[6:0]} - {1'b0, base(2'(r))});
      end
    end
  end
  assign next_row = (row == LAST_ROW) ? 2'd0 : row + 2'd1;
  assign clr      = !in_rs && in_byte[7:2] == 6'd0 && in_byte[1:0] != 2'd0;
  assign accept   = state == IDLE && in_valid && in_ready;
  assign load     = state == INIT || state == WRAP || accept;
  assign ld_byte  = state == INIT ? ini_byte : state == WRAP ? {1'b1, base(next_row)} : in_byte;
  assign ld_wait  = state == INIT ? ini_wait : (accept && clr) ? T_CLR : T_CMD;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= PWR_WAIT;
      cnt <= '0;
      wait_q <= '0;
      idx <= '0;
      byte_q <= '0;
      half <= 1'b0;
      single <= 1'b0;
      trk <= 1'b1;
      wrap_pend <= 1'b0;
      row <= '0;
      col <= '0;
      in_ready <= 1'b0;
      init_done <= 1'b0;
      busy <= 1'b1;
      rs_out <= 1'b0;
      enable_out <= 1'b0;
      data_out <= '0;
    end else begin
      if (load) begin
        byte_q <= ld_byte;
        wait_q <= ld_wait;
        single <= BUS8 || (state == INIT && ini_single);
        half <= 1'b0;
        rs_out <= accept && in_rs;
        data_out <= bus_val(ld_byte, 1'b0);
        state <= SETUP;
      end
      case (state)
        PWR_WAIT:
          if (cnt == T_INIT - 1) begin
            cnt <= '0;
            state <= INIT;
          end else cnt <= cnt + 1;
        IDLE:
          if (accept) begin
            in_ready <= 1'b0;
            busy <= 1'b1;
            if (in_rs) begin
              if (trk) begin
                col <= col + 5'd1;
                wrap_pend <= (col + 5'd1 == NCOL);
              end
            end else if (clr) begin
              row <= '0;
              col <= '0;
              trk <= 1'b1;
            end else if (in_byte[7]) begin
              trk <= hit;
              if (hit) begin
                row <= hit_row;
                col <= hit_col;
              end
            end
          end
        SETUP: begin
          enable_out <= 1'b1;
          state <= E_HI;
        end
        E_HI:
          if (cnt == T_EHI - 1) begin
            cnt <= '0;
            enable_out <= 1'b0;
            state <= E_LO;
          end else cnt <= cnt + 1;
        E_LO:
          if (cnt == T_ELO - 1) begin
            cnt <= '0;
            if (!single && !half) begin
              half <= 1'b1;
              data_out <= bus_val(byte_q, 1'b1);
              state <= SETUP;
            end else state <= WAIT;
          end else cnt <= cnt + 1;
        WAIT:
          if (cnt == wait_q - 1) begin
            cnt <= '0;
            if (!init_done) begin
              if (idx == 3'd7) begin
                init_done <= 1'b1;
                busy <= 1'b0;
                in_ready <= 1'b1;
                state <= IDLE;
              end else begin
                idx <= (BUS8 && idx == 3'd2) ? 3'd4 : idx + 3'd1;
                state <= INIT;
              end
            end else if (wrap_pend) state <= WRAP;
            else begin
              busy <= 1'b0;
              in_ready <= 1'b1;
              state <= IDLE;
            end
          end else cnt <= cnt + 1;
        WRAP: begin
          row <= next_row;
          col <= '0;
          wrap_pend <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_lcd_char_driver.sv
// tb_lcd_char_driver: scoreboard bench for a 4-bit and an 8-bit lcd_char_driver at 1 MHz (1 cycle = 1 us).
module tb_lcd_char_driver;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, rst8_n;
  logic v4, rs4i, v8, rs8i;
  logic [7:0] b4, b8;
  logic rdy4, done4, busy4, rs4, en4, rdy8, done8, busy8, rs8, en8;
  logic [3:0] d4;
  logic [7:0] d8;
  int n_cmp = 0, n_err = 0, p4 = 0, p8 = 0;
  logic [4:0] q4[$];
  logic [8:0] q8[$];
  lcd_char_driver #(.CLK_HZ(1_000_000), .BUS_WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(rdy4), .in_rs(rs4i), .in_byte(b4),
    .init_done(done4), .busy(busy4), .rs_out(rs4), .enable_out(en4), .data_out(d4));
  lcd_char_driver #(.CLK_HZ(1_000_000), .BUS_WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst8_n), .in_valid(v8), .in_ready(rdy8), .in_rs(rs8i), .in_byte(b8),
    .init_done(done8), .busy(busy8), .rs_out(rs8), .enable_out(en8), .data_out(d8));
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  // Monitors: every rising E pops the next expected {rs, bus} and compares; the bus must not change while E is high
  initial begin
    logic prev = 1'b0;
    logic [4:0] cap = '0;
    forever begin
      @(negedge clk);
      if (rst_n && en4 && !prev) begin
        p4++;
        cap = {rs4, d4};
        if (q4.size() == 0) chk("pulse4_unexpected", {27'd0, cap}, 32'hFFFF);
        else chk("pulse4", {27'd0, cap}, {27'd0, q4.pop_front()});
      end
      if (rst_n && !en4 && prev) chk("hold4", {27'd0, rs4, d4}, {27'd0, cap});
      prev = rst_n && en4;
    end
  end
  initial begin
    logic prev = 1'b0;
    logic [8:0] cap = '0;
    forever begin
      @(negedge clk);
      if (rst8_n && en8 && !prev) begin
        p8++;
        cap = {rs8, d8};
        if (q8.size() == 0) chk("pulse8_unexpected", {23'd0, cap}, 32'hFFFF);
        else chk("pulse8", {23'd0, cap}, {23'd0, q8.pop_front()});
      end
      if (rst8_n && !en8 && prev) chk("hold8", {23'd0, rs8, d8}, {23'd0, cap});
      prev = rst8_n && en8;
    end
  end
  task automatic push4(input logic rs, input logic [7:0] b);
    q4.push_back({rs, b[7:4]});
    q4.push_back({rs, b[3:0]});
  endtask
  task automatic init_exp4();
    q4.push_back(5'h03);
    q4.push_back(5'h03);
    q4.push_back(5'h03);
    q4.push_back(5'h02);
    push4(1'b0, 8'h28);
    push4(1'b0, 8'h0C);
    push4(1'b0, 8'h01);
    push4(1'b0, 8'h06);
  endtask
  task automatic send4(input string nm, input logic rs, input logic [7:0] b, input int lat,
                       input logic wrap, input logic [7:0] wb);
    int n;
    n = 0;
    while (!rdy4 && n < 5000) begin @(negedge clk); n++; end
    chk({nm, "_ready"}, {31'd0, rdy4}, 32'd1);
    push4(rs, b);
    if (wrap) push4(1'b0, wb);
    v4 = 1'b1; rs4i = rs; b4 = b;
    @(negedge clk);
    v4 = 1'b0;
    chk({nm, "_drop"}, {31'd0, rdy4}, 32'd0);
    n = 0;
    while (!rdy4 && n < 5000) begin @(negedge clk); n++; end
    chk({nm, "_latency"}, n, lat);
  endtask
  task automatic send8(input string nm, input logic rs, input logic [7:0] b, input int lat);
    int n;
    n = 0;
    while (!rdy8 && n < 5000) begin @(negedge clk); n++; end
    q8.push_back({rs, b});
    v8 = 1'b1; rs8i = rs; b8 = b;
    @(negedge clk);
    v8 = 1'b0;
    chk({nm, "_drop"}, {31'd0, rdy8}, 32'd0);
    n = 0;
    while (!rdy8 && n < 5000) begin @(negedge clk); n++; end
    chk({nm, "_latency"}, n, lat);
  endtask
  initial begin
    int k, early;
    rst_n = 1'b0; rst8_n = 1'b0;
    v4 = 1'b0; rs4i = 1'b0; b4 = '0; v8 = 1'b0; rs8i = 1'b0; b8 = '0;
    repeat (3) @(negedge clk);
    chk("rst_rs", {31'd0, rs4}, 0);
    chk("rst_en", {31'd0, en4}, 0);
    chk("rst_data", {28'd0, d4}, 0);
    chk("rst_ready", {31'd0, rdy4}, 0);
    chk("rst_done", {31'd0, done4}, 0);
    chk("rst_busy", {31'd0, busy4}, 1);
    chk("rst_data8", {24'd0, d8}, 0);
    chk("rst_busy8", {31'd0, busy8}, 1);
    init_exp4();
    q8.push_back(9'h030); q8.push_back(9'h030); q8.push_back(9'h030);
    q8.push_back(9'h038); q8.push_back(9'h00C); q8.push_back(9'h001); q8.push_back(9'h006);
    rst_n = 1'b1; rst8_n = 1'b1;
    k = 0;
    while (!en4 && k < 16000) begin @(negedge clk); k++; end
    chk("first_e_cycle", k, 15002);
    chk("first_e_data", {27'd0, rs4, d4}, 32'h03);
    k = 0;
    while (!(done4 && done8) && k < 30000) begin @(negedge clk); k++; end
    chk("init_done4", {31'd0, done4}, 1);
    chk("init_done8", {31'd0, done8}, 1);
    chk("init_pulses4", p4, 12);
    chk("init_pulses8", p8, 7);
    chk("idle_busy", {31'd0, busy4}, 0);
    chk("idle_ready", {31'd0, rdy4}, 1);
    send4("char_A", 1'b1, 8'h41, 46, 1'b0, 8'h00);
    send4("clear", 1'b0, 8'h01, 1606, 1'b0, 8'h00);
    for (int i = 0; i < 32; i++)
      send4("row_fill", 1'b1, 8'h61 + 8'(i), (i == 15 || i == 31) ? 93 : 46,
            i == 15 || i == 31, i == 15 ? 8'hC0 : 8'h80);
    send4("addr_cf", 1'b0, 8'hCF, 46, 1'b0, 8'h00);
    send4("last_row_wrap", 1'b1, 8'h5A, 93, 1'b1, 8'h80);
    send4("addr_8f", 1'b0, 8'h8F, 46, 1'b0, 8'h00);
    send4("row0_wrap", 1'b1, 8'h59, 93, 1'b1, 8'hC0);
    send4("addr_bad", 1'b0, 8'hA0, 46, 1'b0, 8'h00);
    for (int i = 0; i < 16; i++) send4("untracked", 1'b1, 8'h30 + 8'(i), 46, 1'b0, 8'h00);
    send4("home", 1'b0, 8'h02, 1606, 1'b0, 8'h00);
    for (int i = 0; i < 16; i++)
      send4("after_home", 1'b1, 8'h41 + 8'(i), i == 15 ? 93 : 46, i == 15, 8'hC0);
    send8("bus8_char", 1'b1, 8'h41, 43);
    send8("bus8_home", 1'b0, 8'h02, 1603);
    chk("bus8_pulses", p8, 9);
    k = 0;
    while (!rdy4 && k < 5000) begin @(negedge clk); k++; end
    q4.push_back(5'h15);
    v4 = 1'b1; rs4i = 1'b1; b4 = 8'h5A;
    @(negedge clk);
    v4 = 1'b0;
    k = 0;
    while (!en4 && k < 100) begin @(negedge clk); k++; end
    chk("abort_e_high", {31'd0, en4}, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_en", {31'd0, en4}, 0);
    chk("abort_data", {28'd0, d4}, 0);
    chk("abort_busy", {31'd0, busy4}, 1);
    v4 = 1'b1; rs4i = 1'b1; b4 = 8'h55;
    q4.delete();
    p4 = 0;
    init_exp4();
    push4(1'b1, 8'h55);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    k = 0; early = 0;
    while (!done4 && k < 30000) begin
      @(negedge clk);
      k++;
      if (rdy4 && !done4) early++;
    end
    chk("reinit_done", {31'd0, done4}, 1);
    chk("reinit_no_early_ready", early, 0);
    chk("reinit_pulses", p4, 12);
    @(negedge clk);
    v4 = 1'b0;
    chk("held_accept_drop", {31'd0, rdy4}, 0);
    k = 0;
    while (!rdy4 && k < 5000) begin @(negedge clk); k++; end
    chk("held_latency", k, 46);
    repeat (5) @(negedge clk);
    chk("queue4_empty", q4.size(), 0);
    chk("queue8_empty", q8.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
